// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding and PC constants.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: redirect priority, word alignment and misalignment flag.
module next_pc_mux #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              misaligned,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    raw_target      = jump_en ? jump_target : branch_target;
    redirect        = jump_en | branch_en;
    misaligned      = redirect && (raw_target[1:0] != 2'b00);
    redirect_target = {raw_target[ADDR_W-1:2], 2'b00};
    // A buffered redirect outranks anything presented at ack time.
    if (pend_valid)    next_pc = pend_target;
    else if (redirect) next_pc = redirect_target;
    else               next_pc = pc_plus4;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch handshake FSM and redirect buffering for the MIPS fetch stage.
module fetch_pc_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  output logic              redirect_pending,
  output logic              misalign_err
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic              pend_valid;
  logic              redirect;
  logic              misaligned;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] hold_next_pc;

  next_pc_mux #(.ADDR_W(ADDR_W)) u_next_pc_mux (
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .jump_en         (jump_en),
    .jump_target     (jump_target),
    .branch_en       (branch_en),
    .branch_target   (branch_target),
    .pc_plus4        (pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misaligned      (misaligned),
    .next_pc         (next_pc)
  );

  assign pc_plus4         = pc + PC_INC;
  assign pc_out           = pc;
  assign imem_addr        = pc;
  assign redirect_pending = pend_valid;

  // In HOLD the most recent redirect wins, including one arriving on the release cycle.
  assign hold_next_pc = redirect ? redirect_target : (pend_valid ? pend_target : pc_plus4);

  assign instr_valid = (state == FETCH) && imem_ack && !(pend_valid || redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (state != BOOT && misaligned) misalign_err <= 1'b1;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
              if (redirect) begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
              end
            end else begin
              pc         <= next_pc;
              pend_valid <= 1'b0;
            end
          end else if (redirect) begin
            pend_valid  <= 1'b1;
            pend_target <= redirect_target;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc         <= hold_next_pc;
            state      <= FETCH;
            imem_req   <= 1'b1;
            pend_valid <= 1'b0;
          end else if (redirect) begin
            pend_valid  <= 1'b1;
            pend_target <= redirect_target;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected fetch results are queued by stimulus and checked on ack.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        redirect_pending;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .jump_en          (jump_en),
    .jump_target      (jump_target),
    .branch_en        (branch_en),
    .branch_target    (branch_target),
    .imem_ack         (imem_ack),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .pc_out           (pc_out),
    .pc_plus4         (pc_plus4),
    .instr_valid      (instr_valid),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits gap idle cycles, then acks the current fetch and queues its expected result.
  task automatic fetch(input logic [31:0] exp_pc, input logic exp_valid, input int unsigned gap);
    exp_t e;
    imem_ack = 1'b0;
    repeat (gap) tick();
    e.pc    = exp_pc;
    e.valid = exp_valid;
    sb.push_back(e);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic jump_on_ack(input logic [31:0] cur_pc, input logic [31:0] target);
    jump_en     = 1'b1;
    jump_target = target;
    fetch(cur_pc, 1'b0, 0);
    jump_en     = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (imem_req && imem_ack) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack at pc 0x%08h expected no fetch completion", pc_out);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("fetch_pc", pc_out, e.pc);
            chk("fetch_addr", imem_addr, e.pc);
            chk("instr_valid", 32'(instr_valid), 32'(e.valid));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pending", 32'(redirect_pending), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    chk("boot_req", 32'(imem_req), 32'd0);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);

    // 1: sequential fetch 0,4,8,C
    fetch(32'h0, 1'b1, 1);
    fetch(32'h4, 1'b1, 1);
    fetch(32'h8, 1'b1, 1);
    fetch(32'hC, 1'b1, 1);
    chk("seq_pc", pc_out, 32'h10);

    // 2: jump coincident with ack kills the fetch
    jump_on_ack(32'h10, 32'h0040_0010);
    jump_on_ack(32'h0040_0010, 32'h0040_0100);
    chk("jump_pc", pc_out, 32'h0040_0100);
    chk("jump_pending", 32'(redirect_pending), 32'd0);

    // 3: buffered redirects during a slow fetch, last wins
    jump_on_ack(32'h0040_0100, 32'h20);
    tick();
    branch_en = 1'b1; branch_target = 32'h80;
    tick();
    branch_en = 1'b0;
    chk("pend_after_branch", 32'(redirect_pending), 32'd1);
    jump_en = 1'b1; jump_target = 32'h200;
    tick();
    jump_en = 1'b0;
    chk("pend_after_jump", 32'(redirect_pending), 32'd1);
    fetch(32'h20, 1'b0, 0);
    chk("pend_target_pc", pc_out, 32'h200);
    chk("pend_cleared", 32'(redirect_pending), 32'd0);

    // 4: stall across ack, redirect during HOLD, stray ack ignored
    jump_on_ack(32'h200, 32'h10);
    stall = 1'b1;
    fetch(32'h10, 1'b1, 0);
    chk("hold_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("hold_pc", pc_out, 32'h10);
    jump_en = 1'b1; jump_target = 32'h300;
    tick();
    jump_en = 1'b0;
    tick();
    chk("hold_pending", 32'(redirect_pending), 32'd1);
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_pc2", pc_out, 32'h10);
    stall = 1'b0;
    tick();
    chk("release_pc", pc_out, 32'h300);
    chk("release_req", 32'(imem_req), 32'd1);
    chk("release_pending", 32'(redirect_pending), 32'd0);

    // 5: misaligned target and wrap-around
    jump_on_ack(32'h300, 32'h0000_1002);
    chk("misalign_pc", pc_out, 32'h0000_1000);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    fetch(32'h1000, 1'b1, 0);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
    jump_on_ack(32'h1004, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    fetch(32'hFFFF_FFFC, 1'b1, 0);
    chk("wrap_pc", pc_out, 32'h0);

    // 6: reset mid-fetch with a pending redirect
    jump_en = 1'b1; jump_target = 32'h500;
    tick();
    jump_en = 1'b0;
    chk("pre_rst_pending", 32'(redirect_pending), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pending", 32'(redirect_pending), 32'd0);
    chk("midrst_pc", pc_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("restart_req", 32'(imem_req), 32'd1);
    fetch(32'h0, 1'b1, 1);
    chk("restart_pc", pc_out, 32'h4);
    chk("restart_misalign", 32'(misalign_err), 32'd0);

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter register and next-PC selector for the MIPS fetch stage. It consumes the 32-bit jump target built by the jump-concatenation stage, {PC[31:28], instr_index<<2}, plus the branch target from the branch adder. It drives PC back into that stage and holds the fetch handshake with instruction memory. Redirects that arrive while a fetch is in flight are buffered, and the stale instruction is killed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (only 32 supported)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall from hazard unit; freezes PC advance
jump_en  in  1  jump taken this cycle
jump_target  in  32  concatenated jump address
branch_en  in  1  branch taken this cycle
branch_target  in  32  PC+4+(offset<<2)
imem_ack  in  1  instruction memory read complete (data valid)
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address (= pc_out)
pc_out  out  32  current PC; also feeds jump-concatenation PC input
pc_plus4  out  32  pc_out + 4, wraps modulo 2^32
instr_valid  out  1  one-cycle pulse: fetched word at pc_out is architecturally valid
redirect_pending  out  1  buffered redirect awaiting in-flight fetch
misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (rst_n low, async): pc_out=RESET_PC, imem_req=0, instr_valid=0, redirect_pending=0, misalign_err=0, pending target=0, FSM=BOOT.
- FSM states:
  - BOOT: one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, waiting for ack.
  - HOLD: stall active after a completed fetch; imem_req=0.
- FETCH plus imem_ack:
  - instr_valid=1 unless the fetch is killed.
  - A fetch is killed if a redirect was buffered during it, or a redirect is presented in the same cycle.
  - Next PC, decided by priority:
    - pending redirect target;
    - else jump_target if jump_en;
    - else branch_target if branch_en;
    - else pc_plus4.
  - If stall=1: PC not updated, go to HOLD; a redirect presented this cycle is buffered.
  - If stall=0: PC updated next edge; stay in FETCH; pending cleared.
- FETCH without imem_ack, jump_en|branch_en asserted:
  - Target latched into the pending register (jump wins if both).
  - redirect_pending=1 from the next cycle.
  - A later redirect before ack overwrites the pending target; last wins.
- HOLD:
  - Redirects are buffered in the pending register.
  - On stall deassert: PC <= pending target if any, else pc_plus4. Go to FETCH next cycle.
- Latency: PC update is visible one cycle after the deciding edge. The first imem_req rises in the cycle after BOOT.
- Target alignment:
  - Any redirect target with bits[1:0] != 0 sets misalign_err, which stays set until reset.
  - The used target has bits[1:0] forced to 00.
- Upper-bit rule: jump_target is used as given. This block never re-derives PC[31:28].
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.
- Reset mid-fetch: request dropped immediately, pending discarded, restart at RESET_PC.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Shared package (mips_fetch_pkg): FSM state encoding (BOOT, FETCH, HOLD), RESET_PC default, PC_INC=4.
- One sub-module: next_pc_mux. It is combinational and does the priority select plus alignment force/flag, which keeps the FSM/register logic separate.

Test Plan:
1. Reset release, imem_ack one cycle after each req, no redirects -> pc_out sequence 0, 4, 8, 0xC; instr_valid pulse on each ack.
2. At PC=0x0040_0010, jump_en=1, jump_target=0x0040_0100, coincident with ack -> that fetch is killed (instr_valid=0); next pc_out=0x0040_0100.
3. Fetch at 0x20 with ack delayed 3 cycles:
   - branch_en pulses at cycle 1 with target 0x80, then jump_en pulses at cycle 2 with target 0x200.
   - Expected: redirect_pending=1; on ack, instr_valid=0; pc_out=0x200.
4. stall=1 across an ack at PC=0x10, jump to 0x300 during HOLD, stall=0 -> pc_out=0x300; no fetch issued during HOLD.
5. jump_target=0x0000_1002 -> misalign_err=1 and stays 1; pc_out=0x0000_1000. PC at 0xFFFF_FFFC advancing -> 0x0000_0000.
6. rst_n pulsed low mid-fetch with a redirect pending -> imem_req=0 immediately, redirect_pending=0; restart at RESET_PC.
